// File: rtl/pid_pkg.sv
// Shared constants and FSM encoding for the multiplexed PID controller.
package pid_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int CHN_WIDTH  = 3;
  localparam int NUM_CHN    = 4;
  localparam int RPM_MAX    = 1500;
  localparam int FRAC       = 8;
  localparam int SUM_WIDTH  = 40;

  typedef enum logic [2:0] {
    IDLE,
    S_ERR,
    S_INT,
    S_MUL,
    S_OUT
  } state_e;

endpackage

// File: rtl/pid_mac_unit.sv
// Registered three-term product sum KP*e + KI*integ + KD*d, shared by all channels.
module pid_mac_unit #(
  parameter int          EW = 17,
  parameter int          IW = 18,
  parameter int          SW = 40,
  parameter int unsigned KP = 256,
  parameter int unsigned KI = 16,
  parameter int unsigned KD = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic signed [EW-1:0] e,
  input  logic signed [EW-1:0] d,
  input  logic signed [IW-1:0] integ,
  output logic signed [SW-1:0] sum
);

  localparam logic signed [SW-1:0] KP_S = SW'(KP);
  localparam logic signed [SW-1:0] KI_S = SW'(KI);
  localparam logic signed [SW-1:0] KD_S = SW'(KD);

  logic signed [SW-1:0] sum_d;

  always_comb begin
    sum_d = KP_S * SW'(e) + KI_S * SW'(integ) + KD_S * SW'(d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum_d;
    end
  end

endmodule

// File: rtl/pid_core_mux.sv
// Time-multiplexed PID controller: one shared MAC serves NUM_CHN motor channels per sample tick.
module pid_core_mux #(
  parameter int          DATA_WIDTH = pid_pkg::DATA_WIDTH,
  parameter int          NUM_CHN    = pid_pkg::NUM_CHN,
  parameter int          RPM_MAX    = pid_pkg::RPM_MAX,
  parameter int unsigned KP         = 256,
  parameter int unsigned KI         = 16,
  parameter int unsigned KD         = 0,
  parameter int          FRAC       = pid_pkg::FRAC,
  parameter int          INT_MAX    = 30000
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             sample_tick,
  input  logic                             int_clr,
  input  logic [NUM_CHN*DATA_WIDTH-1:0]    tgt_rpm,
  input  logic [NUM_CHN*DATA_WIDTH-1:0]    meas_rpm,
  output logic                             u_valid_o,
  output logic [pid_pkg::CHN_WIDTH-1:0]    u_chn_o,
  output logic [DATA_WIDTH-1:0]            u_data_o,
  output logic                             busy,
  output logic                             overrun
);

  import pid_pkg::*;

  localparam int EW = DATA_WIDTH + 1;
  localparam int IW = DATA_WIDTH + 2;
  localparam int SW = SUM_WIDTH;

  localparam logic signed [EW-1:0] E_MAX = EW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [IW-1:0] I_MAX = IW'(INT_MAX);
  localparam logic signed [SW-1:0] U_MAX = SW'(RPM_MAX);
  localparam logic [CHN_WIDTH-1:0] CHN_LAST = CHN_WIDTH'(NUM_CHN - 1);

  state_e                         state_q;
  logic [CHN_WIDTH-1:0]           chn_q;
  logic [NUM_CHN*DATA_WIDTH-1:0]  tgt_q, meas_q;
  logic [NUM_CHN*IW-1:0]          integ_q;
  logic [NUM_CHN*EW-1:0]          e_prev_q;
  logic signed [EW-1:0]           e_q, d_q;

  logic signed [DATA_WIDTH-1:0]   tgt_s, meas_s;
  logic signed [EW-1:0]           diff, e_sat, e_prev_s, d_next;
  logic signed [IW-1:0]           integ_s, integ_sum, integ_new;
  logic signed [SW-1:0]           sum, shifted, u_sat;

  always_comb begin
    tgt_s    = $signed(tgt_q[int'(chn_q)*DATA_WIDTH +: DATA_WIDTH]);
    meas_s   = $signed(meas_q[int'(chn_q)*DATA_WIDTH +: DATA_WIDTH]);
    e_prev_s = $signed(e_prev_q[int'(chn_q)*EW +: EW]);
    integ_s  = $signed(integ_q[int'(chn_q)*IW +: IW]);

    // One extra bit keeps tgt-meas exact before symmetric saturation.
    diff = EW'(tgt_s) - EW'(meas_s);
    if (diff > E_MAX)       e_sat = E_MAX;
    else if (diff < -E_MAX) e_sat = -E_MAX;
    else                    e_sat = diff;
    d_next = e_sat - e_prev_s;

    integ_sum = integ_s + IW'(e_q);
    if (integ_sum > I_MAX)       integ_new = I_MAX;
    else if (integ_sum < -I_MAX) integ_new = -I_MAX;
    else                         integ_new = integ_sum;

    shifted = sum >>> FRAC;
    if (shifted > U_MAX)       u_sat = U_MAX;
    else if (shifted < -U_MAX) u_sat = -U_MAX;
    else                       u_sat = shifted;
  end

  // The MAC register only loads in S_MUL, so the output holds between strobes.
  assign u_data_o = DATA_WIDTH'(u_sat);

  pid_mac_unit #(
    .EW (EW),
    .IW (IW),
    .SW (SW),
    .KP (KP),
    .KI (KI),
    .KD (KD)
  ) u_mac (
    .clk   (clk),
    .rstn  (rstn),
    .en    (state_q == S_MUL),
    .e     (e_q),
    .d     (d_q),
    .integ (integ_s),
    .sum   (sum)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      chn_q     <= '0;
      tgt_q     <= '0;
      meas_q    <= '0;
      integ_q   <= '0;
      e_prev_q  <= '0;
      e_q       <= '0;
      d_q       <= '0;
      u_valid_o <= 1'b0;
      u_chn_o   <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      u_valid_o <= 1'b0;
      overrun   <= sample_tick && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (int_clr) begin
            integ_q  <= '0;
            e_prev_q <= '0;
          end
          if (sample_tick) begin
            tgt_q   <= tgt_rpm;
            meas_q  <= meas_rpm;
            chn_q   <= '0;
            busy    <= 1'b1;
            state_q <= S_ERR;
          end
        end
        S_ERR: begin
          e_q     <= e_sat;
          d_q     <= d_next;
          state_q <= S_INT;
        end
        S_INT: begin
          integ_q[int'(chn_q)*IW +: IW]  <= integ_new;
          e_prev_q[int'(chn_q)*EW +: EW] <= e_q;
          state_q                        <= S_MUL;
        end
        S_MUL: begin
          u_valid_o <= 1'b1;
          u_chn_o   <= chn_q;
          state_q   <= S_OUT;
        end
        S_OUT: begin
          if (chn_q == CHN_LAST) begin
            chn_q   <= '0;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else begin
            chn_q   <= chn_q + 1'b1;
            state_q <= S_ERR;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_core_mux.sv
// Two differently-tuned controllers on shared stimulus, checked against a per-round arithmetic model.
module tb_pid_core_mux;

  localparam int DW = 16, NC = 4, UMAX = 1500, FRAC = 8, IMAX = 30000, EMAX = 32767;
  localparam int KP_A = 256, KI_A = 16, KD_A = 0;
  localparam int KP_B = 64,  KI_B = 32, KD_B = 256;

  logic clk = 1'b0, rstn = 1'b0, sample_tick = 1'b0, int_clr = 1'b0;
  logic [NC*DW-1:0] tgt_rpm = '0, meas_rpm = '0;
  logic va, vb, ba, bb, oa, ob;
  logic [2:0] ca, cb;
  logic [DW-1:0] da, db;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pid_core_mux #(.KP(KP_A), .KI(KI_A), .KD(KD_A)) dut_a (
    .clk(clk), .rstn(rstn), .sample_tick(sample_tick), .int_clr(int_clr),
    .tgt_rpm(tgt_rpm), .meas_rpm(meas_rpm), .u_valid_o(va), .u_chn_o(ca),
    .u_data_o(da), .busy(ba), .overrun(oa));

  pid_core_mux #(.KP(KP_B), .KI(KI_B), .KD(KD_B)) dut_b (
    .clk(clk), .rstn(rstn), .sample_tick(sample_tick), .int_clr(int_clr),
    .tgt_rpm(tgt_rpm), .meas_rpm(meas_rpm), .u_valid_o(vb), .u_chn_o(cb),
    .u_data_o(db), .busy(bb), .overrun(ob));

  typedef struct { int cyc; int chn; int u; } exp_t;
  exp_t q0[$], q1[$];
  longint integ_m[2][NC], eprev_m[2][NC];
  int kp_m[2] = '{KP_A, KP_B};
  int ki_m[2] = '{KI_A, KI_B};
  int kd_m[2] = '{KD_A, KD_B};
  int last_chn[2] = '{0, 0};
  int last_u[2] = '{0, 0};
  bit active = 0;
  int start = -100, ovr_at = -100;
  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input int i, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[dut%0d] cyc=%0d: got %0d, want %0d", name, i, cyc, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < NC; c++) begin
        integ_m[i][c] = 0;
        eprev_m[i][c] = 0;
      end
  endtask

  // One control round computed all at once when the tick is accepted.
  task automatic model_round(input int i, input int n);
    longint t, m, e, d, s, u;
    exp_t x;
    for (int c = 0; c < NC; c++) begin
      t = longint'($signed(tgt_rpm[c*DW +: DW]));
      m = longint'($signed(meas_rpm[c*DW +: DW]));
      e = t - m;
      if (e > EMAX) e = EMAX;
      if (e < -EMAX) e = -EMAX;
      d = e - eprev_m[i][c];
      eprev_m[i][c] = e;
      integ_m[i][c] = integ_m[i][c] + e;
      if (integ_m[i][c] > IMAX) integ_m[i][c] = IMAX;
      if (integ_m[i][c] < -IMAX) integ_m[i][c] = -IMAX;
      s = kp_m[i] * e + ki_m[i] * integ_m[i][c] + kd_m[i] * d;
      u = s >>> FRAC;
      if (u > UMAX) u = UMAX;
      if (u < -UMAX) u = -UMAX;
      x.cyc = n + 4 * c + 3;
      x.chn = c;
      x.u = int'(u);
      if (i == 0) q0.push_back(x);
      else q1.push_back(x);
    end
  endtask

  // Effect of the inputs presented at clock edge n.
  task automatic model_edge(input int n, input bit tick, input bit clr);
    if (!active || n > start + 4 * NC) begin
      active = 0;
      if (clr) clear_model();
      if (tick) begin
        active = 1;
        start = n;
        model_round(0, n);
        model_round(1, n);
      end
    end else if (tick) begin
      ovr_at = n;
    end
  endtask

  task automatic check_inst(input int i, input logic v, input logic [2:0] c,
                            input logic [DW-1:0] d, input logic b, input logic o);
    exp_t it;
    bit hit = 0;
    if (i == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin it = q0.pop_front(); hit = 1; end
    if (i == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin it = q1.pop_front(); hit = 1; end
    chk("valid", i, v, hit);
    chk("busy", i, b, active && cyc >= start && cyc < start + 4 * NC);
    chk("overrun", i, o, cyc == ovr_at);
    if (hit) begin
      last_chn[i] = it.chn;
      last_u[i] = it.u;
    end
    chk("chn", i, c, last_chn[i]);
    chk("data", i, $signed(d), last_u[i]);
  endtask

  always @(negedge clk) begin
    check_inst(0, va, ca, da, ba, oa);
    check_inst(1, vb, cb, db, bb, ob);
  end

  task automatic drive(input bit tick, input bit clr, input logic [NC*DW-1:0] t,
                       input logic [NC*DW-1:0] m);
    @(negedge clk);
    #1;
    sample_tick = tick;
    int_clr = clr;
    tgt_rpm = t;
    meas_rpm = m;
    if (rstn) model_edge(cyc + 1, tick, clr);
  endtask

  function automatic logic [NC*DW-1:0] rand_vec();
    logic [NC*DW-1:0] r;
    for (int c = 0; c < NC; c++) begin
      if ($urandom_range(0, 3) == 0) r[c*DW +: DW] = DW'($urandom);
      else r[c*DW +: DW] = DW'(int'($urandom_range(0, 4000)) - 2000);
    end
    return r;
  endfunction

  function automatic logic [NC*DW-1:0] fill(input int v0, input int vr);
    logic [NC*DW-1:0] r;
    for (int c = 0; c < NC; c++) r[c*DW +: DW] = DW'(c == 0 ? v0 : vr);
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, tgt_rpm, meas_rpm);
  endtask

  initial begin
    logic [NC*DW-1:0] tv, mv;
    int s;
    clear_model();
    repeat (3) @(negedge clk);
    #1 rstn = 1'b1;
    idle(2);

    drive(1'b1, 1'b0, fill(1000, 200), fill(400, -300));
    idle(20);
    drive(1'b1, 1'b0, fill(32767, 32767), fill(-32768, -32768));
    idle(20);
    drive(1'b1, 1'b0, fill(-32768, -32768), fill(32767, 32767));
    idle(20);

    // Tick in the sixth busy cycle must be dropped with a single overrun pulse.
    drive(1'b1, 1'b0, fill(100, 50), fill(0, 0));
    idle(5);
    drive(1'b1, 1'b0, fill(900, 900), fill(0, 0));
    idle(20);

    drive(1'b0, 1'b1, tgt_rpm, meas_rpm);
    drive(1'b1, 1'b0, fill(100, 100), fill(0, 0));
    idle(20);
    drive(1'b1, 1'b1, fill(100, 150), fill(0, 0));
    idle(20);

    // Abort a round while channel 2 is in its multiply cycle.
    drive(1'b1, 1'b0, fill(700, -500), fill(100, 0));
    s = start;
    repeat (10) drive(1'b0, 1'b0, tgt_rpm, meas_rpm);
    @(negedge clk);
    #1;
    if (cyc != s + 10) chk("rst_align", 0, cyc, s + 10);
    rstn = 1'b0;
    q0.delete();
    q1.delete();
    active = 0;
    ovr_at = -100;
    clear_model();
    last_chn = '{0, 0};
    last_u = '{0, 0};
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    idle(2);
    drive(1'b1, 1'b0, fill(700, -500), fill(100, 0));
    idle(20);

    for (int k = 0; k < 1500; k++) begin
      tv = rand_vec();
      mv = rand_vec();
      drive($urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0, tv, mv);
    end
    idle(25);
    chk("drain", 0, q0.size() + q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pid_core_mux.md
PID_CORE_MUX -- requirements
Module: pid_core_mux

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the signed width of rpm and u data.
REQ-002 The block SHALL have parameter NUM_CHN, default 4, giving the number of motor channels; CHN_WIDTH is fixed at 3.
REQ-003 The block SHALL have parameter RPM_MAX, default 1500, giving the output saturation magnitude.
REQ-004 The block SHALL have parameters KP, KI and KD, defaults 256, 16 and 0, each an unsigned Q8.8 gain.
REQ-005 The block SHALL have parameter FRAC, default 8, giving the gain fraction bits.
REQ-006 The block SHALL have parameter INT_MAX, default 30000, giving the integrator clamp magnitude.
REQ-007 Port clk SHALL be a 1-bit input and the single clock; all logic is on its rising edge.
REQ-008 Port rstn SHALL be a 1-bit input: asynchronous, active-low reset.
REQ-009 Port sample_tick SHALL be a 1-bit input: one-cycle pulse that starts a control round.
REQ-010 Port int_clr SHALL be a 1-bit input: level request to clear the integrators and previous errors.
REQ-011 Port tgt_rpm SHALL be an input of NUM_CHN*DATA_WIDTH bits: packed signed targets, channel 0 in the LSBs.
REQ-012 Port meas_rpm SHALL be an input of NUM_CHN*DATA_WIDTH bits: packed signed measured speeds, same packing.
REQ-013 Port u_valid_o SHALL be a 1-bit output: one-cycle strobe qualifying u_chn_o and u_data_o.
REQ-014 Port u_chn_o SHALL be a CHN_WIDTH-bit output: channel index of the current result.
REQ-015 Port u_data_o SHALL be a DATA_WIDTH-bit output: signed controller output in [-RPM_MAX, +RPM_MAX].
REQ-016 Port busy SHALL be a 1-bit output that is high while a round is in progress.
REQ-017 Port overrun SHALL be a 1-bit output: one-cycle pulse when sample_tick arrives while busy.

Function
REQ-018 The FSM SHALL have states IDLE, S_ERR, S_INT, S_MUL and S_OUT, plus a channel counter chn of 0..NUM_CHN-1.
REQ-019 In IDLE, a sample_tick seen at edge N SHALL snapshot tgt_rpm and meas_rpm, set chn=0 and enter S_ERR at edge N.
REQ-020 State progression SHALL be S_ERR→S_INT→S_MUL→S_OUT, one cycle each; S_OUT goes to S_ERR with chn+1, or to IDLE after chn=NUM_CHN-1.
REQ-021 u_valid_o SHALL be high only during S_OUT; for tick at edge N, channel k is valid in the cycle after edge N+4k+3.
REQ-022 busy SHALL be high in every non-IDLE state, for 4*NUM_CHN cycles per round.
REQ-023 S_ERR SHALL compute e = tgt-meas with 17-bit math saturated to ±(2^(DATA_WIDTH-1)-1), and d = e - e_prev[chn].
REQ-024 S_INT SHALL compute integ[chn] = clamp(integ[chn]+e, ±INT_MAX) and update e_prev[chn] = e.
REQ-025 S_MUL SHALL register sum = KP*e + KI*integ + KD*d as a 40-bit signed value.
REQ-026 S_OUT SHALL drive u = sum >>> FRAC (arithmetic shift, floor), saturated to ±RPM_MAX, on u_data_o.
REQ-027 A sample_tick while busy SHALL be ignored, and overrun SHALL pulse in the following cycle.
REQ-028 int_clr SHALL act only in IDLE: all integ and e_prev are zeroed at the next edge, and a coincident sample_tick is served afterwards with the cleared state.
REQ-029 Between strobes, u_chn_o and u_data_o SHALL hold their last values.

Reset
REQ-030 On rstn low, the state SHALL go to IDLE, chn to 0, and all integ and e_prev to 0.
REQ-031 On rstn low, u_valid_o, u_chn_o, u_data_o, busy and overrun SHALL all be 0.
REQ-032 A reset asserted mid-round SHALL abort the round, so that no further strobe occurs until a new tick after release.

Structure
REQ-033 A shared package pid_pkg SHALL hold DATA_WIDTH, CHN_WIDTH, NUM_CHN, RPM_MAX, FRAC and the FSM state encoding.
REQ-034 Sub-module pid_mac_unit SHALL implement the three-product sum with its output register, shared across channels.

Verification
REQ-035 KP=256, KI=KD=0; tgt0=1000, meas0=400; tick → ch0 strobe 4 cycles later with u=600, then ch1..3 strobes at 4-cycle spacing.
REQ-036 KP=256; tgt=1500, meas=-1500 → u=+1500; tgt=-1500, meas=1500 → u=-1500 (saturation).
REQ-037 KP=0, KI=256; e=100 on three ticks → u=100, 200, 300; then assert int_clr in IDLE and tick → u=100.
REQ-038 KD=256 only; e=100 then e=150 → u=100, then 50.
REQ-039 Tick at round cycle 5 → overrun pulses once, the round completes unchanged, and exactly 4 strobes occur.
REQ-040 Assert rstn during ch2's S_MUL → all outputs 0 and no strobe; the next tick gives integrators starting from 0.
